// File: rtl/pdm_deserializer_if.sv
// pdm_deserializer_if: AXI-Stream link carrying packed PDM words to the decimator
interface pdm_deserializer_if #(parameter int WORD_W = 16);
    logic [WORD_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/pdm_deserializer.sv
// pdm_deserializer: packs a synchronized PDM bit stream into AXI-Stream words
module pdm_deserializer #(
    parameter int WORD_W     = 16,
    parameter int SAMPLE_DLY = 2,
    parameter int FRAME_LEN  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               sample_en,
    input  logic               pdm_data,
    pdm_deserializer_if.master m_axis,
    output logic               overflow,
    input  logic               clr_overflow
);
    localparam int BC_W = $clog2(WORD_W);
    localparam int WC_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    localparam int AW   = WORD_W - 1;
    typedef enum logic {IDLE, FILL} state_t;
    state_t          state, state_nxt;
    logic [1:0]      sync;
    logic            cap, capture, done, can_load, last_word;
    logic [BC_W-1:0] bit_cnt;
    logic [WC_W-1:0] word_cnt;
    logic [AW-1:0]   asm_reg;
    logic [WORD_W-1:0] word;

    // two-flop synchronizer for the asynchronous mic pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else sync <= {sync[0], pdm_data};
    end

    if (SAMPLE_DLY == 0) begin : g_nodly
        assign cap = sample_en;
    end else begin : g_dly
        logic [SAMPLE_DLY-1:0] dly;
        // strobe delay line aligning capture with the synchronized data
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dly <= '0;
            else dly <= SAMPLE_DLY'({dly, sample_en});
        end
        assign cap = dly[SAMPLE_DLY-1];
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // next state plus capture/complete/load decisions
    always_comb begin
        state_nxt = enable ? FILL : IDLE;
        capture   = (state == FILL) && enable && cap;
        done      = capture && (bit_cnt == BC_W'(WORD_W - 1));
        can_load  = !m_axis.tvalid || m_axis.tready;
        last_word = word_cnt == WC_W'(FRAME_LEN - 1);
        word      = {asm_reg, sync[1]};
    end

    // assembly register; disabling throws away the partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            asm_reg <= '0;
        end else if (!enable) begin
            bit_cnt <= '0;
        end else if (capture) begin
            asm_reg <= AW'({asm_reg, sync[1]});
            bit_cnt <= done ? '0 : bit_cnt + 1'b1;
        end
    end

    // output register, frame counter and sticky drop flag (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            word_cnt      <= '0;
            overflow      <= 1'b0;
        end else begin
            if (done && can_load) begin
                m_axis.tdata  <= word;
                m_axis.tvalid <= 1'b1;
                m_axis.tlast  <= last_word;
                word_cnt      <= last_word ? '0 : word_cnt + 1'b1;
            end else if (m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
            overflow <= (done && !can_load) || (overflow && !clr_overflow);
        end
    end
endmodule

// File: tb/tb_pdm_deserializer.sv
// tb_pdm_deserializer: directed checks of packing, framing, back-pressure and alignment
module tb_pdm_deserializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic sample_en = 1'b0;
    logic pdm_data = 1'b0;
    logic clr_overflow = 1'b0;
    logic overflow;
    int total = 0;
    int passed = 0;
    int xfers = 0;
    int lasts = 0;
    int last_idx = 0;
    int aa_cnt = 0;
    logic [15:0] last_data = '0;
    logic [15:0] w;

    pdm_deserializer_if #(.WORD_W(16)) axis ();

    pdm_deserializer #(.WORD_W(16), .SAMPLE_DLY(2), .FRAME_LEN(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .sample_en(sample_en),
        .pdm_data(pdm_data),
        .m_axis(axis),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    // record every accepted word
    always @(posedge clk) begin
        if (rst_n && axis.tvalid && axis.tready) begin
            xfers <= xfers + 1;
            last_data <= axis.tdata;
            if (axis.tdata == 16'hAAAA) aa_cnt <= aa_cnt + 1;
            if (axis.tlast) begin
                lasts <= lasts + 1;
                last_idx <= xfers + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // strobe sampled at the next edge; returns one cycle before the capture edge
    task automatic strobe(input logic b);
        pdm_data = b;
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        strobe(b);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) send_bit(v[i]);
    endtask

    // pin holds the inverse until just after the strobe rises, then takes the real bit
    task automatic late_bit(input logic b);
        pdm_data = ~b;
        @(negedge clk);
        sample_en = 1'b1;
        #4 pdm_data = b;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        axis.tready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_tdata", axis.tdata, 0);
        chk("rst_tlast", axis.tlast, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge clk);
        enable = 1'b1;
        send_word(16'hFFFF);
        chk("held_before_rst", axis.tdata, 16'hFFFF);
        repeat (7) send_bit(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", axis.tvalid, 0);
        chk("async_rst_tdata", axis.tdata, 0);
        chk("async_rst_tlast", axis.tlast, 0);
        @(negedge clk);
        rst_n = 1'b1;
        axis.tready = 1'b1;
        w = 16'hAAAA;
        for (int i = 15; i >= 1; i--) send_bit(w[i]);
        chk("fresh_15bits_tvalid", axis.tvalid, 0);
        chk("fresh_15bits_xfers", xfers, 0);
        strobe(w[0]);
        chk("pre_capture_tvalid", axis.tvalid, 0);
        @(negedge clk);
        chk("word1_tvalid", axis.tvalid, 1);
        chk("word1_tdata", axis.tdata, 16'hAAAA);
        chk("word1_tlast", axis.tlast, 0);
        @(negedge clk);
        repeat (63) send_word(16'hAAAA);
        repeat (2) @(negedge clk);
        chk("frame1_xfers", xfers, 64);
        chk("frame1_aa_words", aa_cnt, 64);
        chk("frame1_tlast_cnt", lasts, 1);
        chk("frame1_tlast_idx", last_idx, 64);
        axis.tready = 1'b0;
        send_word(16'h1234);
        chk("bp_word1_tvalid", axis.tvalid, 1);
        chk("bp_word1_tdata", axis.tdata, 16'h1234);
        chk("bp_no_overflow", overflow, 0);
        send_word(16'hFFFF);
        chk("bp_drop_overflow", overflow, 1);
        chk("bp_word1_stable", axis.tdata, 16'h1234);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("clr_overflow", overflow, 0);
        for (int i = 0; i < 15; i++) send_bit(1'b0);
        strobe(1'b0);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("set_beats_clear", overflow, 1);
        chk("bp_word1_still", axis.tdata, 16'h1234);
        @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        axis.tready = 1'b1;
        @(negedge clk);
        axis.tready = 1'b0;
        chk("bp_drain_tvalid", axis.tvalid, 0);
        chk("bp_drain_data", last_data, 16'h1234);
        send_word(16'h0F0F);
        chk("sc_first_tdata", axis.tdata, 16'h0F0F);
        w = 16'hF0F0;
        for (int i = 15; i >= 1; i--) send_bit(w[i]);
        strobe(w[0]);
        axis.tready = 1'b1;
        @(negedge clk);
        axis.tready = 1'b0;
        chk("sc_tvalid", axis.tvalid, 1);
        chk("sc_tdata", axis.tdata, 16'hF0F0);
        chk("sc_no_overflow", overflow, 0);
        chk("sc_drained", last_data, 16'h0F0F);
        axis.tready = 1'b1;
        @(negedge clk);
        axis.tready = 1'b0;
        send_word(16'h5555);
        repeat (7) send_bit(1'b0);
        enable = 1'b0;
        @(negedge clk);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("en_off_tvalid", axis.tvalid, 1);
        chk("en_off_tdata", axis.tdata, 16'h5555);
        enable = 1'b1;
        @(negedge clk);
        chk("en_on_tdata", axis.tdata, 16'h5555);
        axis.tready = 1'b1;
        @(negedge clk);
        axis.tready = 1'b0;
        chk("en_drain_data", last_data, 16'h5555);
        chk("en_drain_tvalid", axis.tvalid, 0);
        repeat (16) send_bit(1'b1);
        chk("en_new_tdata", axis.tdata, 16'hFFFF);
        chk("en_new_tvalid", axis.tvalid, 1);
        chk("en_no_overflow", overflow, 0);
        axis.tready = 1'b1;
        @(negedge clk);
        axis.tready = 1'b0;
        w = 16'hB38E;
        for (int i = 15; i >= 0; i--) late_bit(w[i]);
        chk("dly_tdata", axis.tdata, 16'hB38E);
        chk("dly_tvalid", axis.tvalid, 1);
        axis.tready = 1'b1;
        repeat (58) send_word(16'h0001);
        repeat (2) @(negedge clk);
        chk("frame2_xfers", xfers, 128);
        chk("frame2_tlast_cnt", lasts, 2);
        chk("frame2_tlast_idx", last_idx, 128);
        chk("final_overflow", overflow, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
